// File: rtl/div_share_ctrl.sv
// div_share_ctrl: round-robin controller sharing one iterative divider between
// two requesters. Define DIV_RESULT_CACHE_EN to keep a quotient/remainder cache.
`ifndef DIV_OP_WIDTH
`define DIV_OP_WIDTH 2
`endif
`ifndef DIV_OP_DIV
`define DIV_OP_DIV 2'd0
`endif
`ifndef DIV_OP_DIVU
`define DIV_OP_DIVU 2'd1
`endif
`ifndef DIV_OP_REM
`define DIV_OP_REM 2'd2
`endif
`ifndef DIV_OP_REMU
`define DIV_OP_REMU 2'd3
`endif

module div_share_ctrl #(
    parameter int XLEN = 32,
    parameter int OPW  = `DIV_OP_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    input  logic [2*OPW-1:0]  req_op,
    input  logic [2*XLEN-1:0] req_divident,
    input  logic [2*XLEN-1:0] req_divisor,
    output logic [1:0]        req_ready,
    output logic [XLEN-1:0]   req_rslt,
    output logic              div_valid,
    output logic [OPW-1:0]    div_op,
    output logic [XLEN-1:0]   div_divident,
    output logic [XLEN-1:0]   div_divisor,
    input  logic              div_ready,
    input  logic [XLEN-1:0]   div_rslt
);

`ifdef DIV_RESULT_CACHE_EN
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, CAP2} state_t;
`else
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
`endif

    localparam logic [OPW-1:0]  OP_DIV   = OPW'(`DIV_OP_DIV);
    localparam logic [OPW-1:0]  OP_DIVU  = OPW'(`DIV_OP_DIVU);
    localparam logic [OPW-1:0]  OP_REM   = OPW'(`DIV_OP_REM);
    localparam logic [OPW-1:0]  OP_REMU  = OPW'(`DIV_OP_REMU);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    function automatic logic op_is_div(input logic [OPW-1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_signed(input logic [OPW-1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    state_t          state, state_d;
    logic            rr_ptr, rr_d;
    logic            gnt, gnt_d;
    logic [OPW-1:0]  op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic            valid_d;
    logic [1:0]      ready_d;
    logic [XLEN-1:0] rslt_d;

    logic [1:0]      req_eff;
    logic            sel;
    logic [OPW-1:0]  sel_op;
    logic [XLEN-1:0] sel_a;
    logic [XLEN-1:0] sel_b;
    logic            sel_signed;
    logic            sel_is_div;
    logic            quick;
    logic [XLEN-1:0] quick_rslt;

`ifdef DIV_RESULT_CACHE_EN
    logic            c_v, cv_d;
    logic            c_s, cs_d;
    logic [XLEN-1:0] c_a, ca_d;
    logic [XLEN-1:0] c_b, cb_d;
    logic [XLEN-1:0] c_q, cq_d;
    logic [XLEN-1:0] c_r, cr_d;
    logic            hit;

    function automatic logic [OPW-1:0] op_comp(input logic [OPW-1:0] op);
        logic [OPW-1:0] r;
        r = OP_DIV;
        case (op)
            OP_DIV:  r = OP_REM;
            OP_REM:  r = OP_DIV;
            OP_DIVU: r = OP_REMU;
            default: r = OP_DIVU;
        endcase
        return r;
    endfunction

    assign div_op = (state == CAP2) ? op_comp(op_q) : op_q;
`else
    assign div_op = op_q;
`endif

    assign div_divident = a_q;
    assign div_divisor  = b_q;

    // a port completing this cycle must not be re-granted on its stale valid
    always_comb begin
        req_eff    = req_valid & ~req_ready;
        sel        = (req_eff == 2'b11) ? rr_ptr : req_eff[1];
        sel_op     = sel ? req_op[OPW +: OPW] : req_op[0 +: OPW];
        sel_a      = sel ? req_divident[XLEN +: XLEN] : req_divident[0 +: XLEN];
        sel_b      = sel ? req_divisor[XLEN +: XLEN] : req_divisor[0 +: XLEN];
        sel_signed = op_signed(sel_op);
        sel_is_div = op_is_div(sel_op);
`ifdef DIV_RESULT_CACHE_EN
        hit = c_v && (sel_a == c_a) && (sel_b == c_b) && (sel_signed == c_s);
`endif
        quick      = 1'b0;
        quick_rslt = '0;
        priority case (1'b1)
            (sel_b == '0): begin
                quick      = 1'b1;
                quick_rslt = sel_is_div ? ALL_ONES : sel_a;
            end
            (sel_signed && sel_a == INT_MIN && sel_b == ALL_ONES): begin
                quick      = 1'b1;
                quick_rslt = sel_is_div ? INT_MIN : '0;
            end
`ifdef DIV_RESULT_CACHE_EN
            hit: begin
                quick      = 1'b1;
                quick_rslt = sel_is_div ? c_q : c_r;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d = state;
        rr_d    = rr_ptr;
        gnt_d   = gnt;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        valid_d = div_valid;
        ready_d = '0;
        rslt_d  = req_rslt;
`ifdef DIV_RESULT_CACHE_EN
        cv_d = c_v;
        cs_d = c_s;
        ca_d = c_a;
        cb_d = c_b;
        cq_d = c_q;
        cr_d = c_r;
`endif
        case (state)
            IDLE: begin
                if (|req_eff) begin
                    gnt_d = sel;
                    rr_d  = ~sel;
                    op_d  = sel_op;
                    a_d   = sel_a;
                    b_d   = sel_b;
                    if (quick) begin
                        rslt_d       = quick_rslt;
                        ready_d[sel] = 1'b1;
                        state_d      = DONE;
                    end else begin
                        valid_d = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (div_ready) begin
                    valid_d = 1'b0;
`ifdef DIV_RESULT_CACHE_EN
                    cv_d = 1'b0;
                    if (op_is_div(op_q)) cq_d = div_rslt;
                    else cr_d = div_rslt;
                    state_d = CAP2;
`else
                    rslt_d       = div_rslt;
                    ready_d[gnt] = 1'b1;
                    state_d      = DONE;
`endif
                end
            end
            DONE: state_d = IDLE;
`ifdef DIV_RESULT_CACHE_EN
            // divider still holds both results; div_op is flipped here
            CAP2: begin
                if (op_is_div(op_q)) begin
                    cr_d   = div_rslt;
                    rslt_d = c_q;
                end else begin
                    cq_d   = div_rslt;
                    rslt_d = c_r;
                end
                ca_d         = a_q;
                cb_d         = b_q;
                cs_d         = op_signed(op_q);
                cv_d         = 1'b1;
                ready_d[gnt] = 1'b1;
                state_d      = DONE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            gnt       <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            div_valid <= 1'b0;
            req_ready <= '0;
            req_rslt  <= '0;
`ifdef DIV_RESULT_CACHE_EN
            c_v <= 1'b0;
            c_s <= 1'b0;
            c_a <= '0;
            c_b <= '0;
            c_q <= '0;
            c_r <= '0;
`endif
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_d;
            gnt       <= gnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            div_valid <= valid_d;
            req_ready <= ready_d;
            req_rslt  <= rslt_d;
`ifdef DIV_RESULT_CACHE_EN
            c_v <= cv_d;
            c_s <= cs_d;
            c_a <= ca_d;
            c_b <= cb_d;
            c_q <= cq_d;
            c_r <= cr_d;
`endif
        end
    end

endmodule

// File: tb/tb_div_share_ctrl.sv
// tb_div_share_ctrl: scoreboard bench for div_share_ctrl with a behavioural
// 32-cycle divider and a transaction-level reference model.
`ifndef DIV_OP_WIDTH
`define DIV_OP_WIDTH 2
`endif
`ifndef DIV_OP_DIV
`define DIV_OP_DIV 2'd0
`endif
`ifndef DIV_OP_DIVU
`define DIV_OP_DIVU 2'd1
`endif
`ifndef DIV_OP_REM
`define DIV_OP_REM 2'd2
`endif
`ifndef DIV_OP_REMU
`define DIV_OP_REMU 2'd3
`endif

module tb_div_share_ctrl;

    localparam int OPW = `DIV_OP_WIDTH;
    localparam logic [OPW-1:0] DIV  = OPW'(`DIV_OP_DIV);
    localparam logic [OPW-1:0] DIVU = OPW'(`DIV_OP_DIVU);
    localparam logic [OPW-1:0] REM  = OPW'(`DIV_OP_REM);
    localparam logic [OPW-1:0] REMU = OPW'(`DIV_OP_REMU);
`ifdef DIV_RESULT_CACHE_EN
    localparam bit CACHE    = 1'b1;
    localparam int NORM_LAT = 37;
`else
    localparam bit CACHE    = 1'b0;
    localparam int NORM_LAT = 36;
`endif

    logic            clk;
    logic            reset;
    logic [1:0]      req_valid;
    logic [2*OPW-1:0] req_op;
    logic [63:0]     req_divident;
    logic [63:0]     req_divisor;
    logic [1:0]      req_ready;
    logic [31:0]     req_rslt;
    logic            div_valid;
    logic [OPW-1:0]  div_op;
    logic [31:0]     div_divident;
    logic [31:0]     div_divisor;
    logic            div_ready;
    logic [31:0]     div_rslt;

    div_share_ctrl #(.XLEN(32), .OPW(OPW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_op(req_op),
        .req_divident(req_divident), .req_divisor(req_divisor),
        .req_ready(req_ready), .req_rslt(req_rslt),
        .div_valid(div_valid), .div_op(div_op),
        .div_divident(div_divident), .div_divisor(div_divisor),
        .div_ready(div_ready), .div_rslt(div_rslt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_op(input logic [OPW-1:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic s, d;
        logic signed [31:0] sa, sb;
        s = (op == DIV) || (op == REM);
        d = (op == DIV) || (op == DIVU);
        sa = a;
        sb = b;
        if (b == 0) return d ? 32'hFFFF_FFFF : a;
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return d ? 32'h8000_0000 : 32'h0;
        if (s) return d ? 32'(sa / sb) : 32'(sa % sb);
        return d ? a / b : a % b;
    endfunction

    // behavioural divider: starts on valid while idle, ready pulse 34 cycles later
    logic        dv_busy = 1'b0;
    int          dv_cnt = 0;
    logic [31:0] dv_q, dv_r;
    int          div_starts = 0;
    always @(posedge clk) begin
        if (reset) begin
            dv_busy <= 1'b0;
        end else if (!dv_busy) begin
            if (div_valid) begin
                dv_busy    <= 1'b1;
                dv_cnt     <= 0;
                div_starts <= div_starts + 1;
                if (div_op == DIV || div_op == REM) begin
                    dv_q <= ref_op(DIV, div_divident, div_divisor);
                    dv_r <= ref_op(REM, div_divident, div_divisor);
                end else begin
                    dv_q <= ref_op(DIVU, div_divident, div_divisor);
                    dv_r <= ref_op(REMU, div_divident, div_divisor);
                end
            end
        end else begin
            dv_cnt <= dv_cnt + 1;
            if (dv_cnt == 33) dv_busy <= 1'b0;
        end
    end
    assign div_ready = dv_busy && (dv_cnt == 33);
    assign div_rslt  = (div_op == DIV || div_op == DIVU) ? dv_q : dv_r;

    typedef struct {
        int          port;
        logic [31:0] rslt;
        longint      cyc;
        string       name;
    } exp_t;
    exp_t sbq[$];

    task automatic fail_line(input string name, input logic [63:0] got,
                             input logic [63:0] want);
        failures++;
        $display("FAIL %s got=%0h want=%0h", name, got, want);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (req_ready != 2'b00) begin
            if (sbq.size() == 0) begin
                checks++;
                fail_line("unexpected_ready", {62'b0, req_ready}, 64'h0);
            end else begin
                e = sbq.pop_front();
                checks++;
                if (req_ready != (2'b01 << e.port))
                    fail_line({e.name, "_port"}, {62'b0, req_ready},
                              64'(2'b01 << e.port));
                checks++;
                if (req_rslt != e.rslt)
                    fail_line({e.name, "_rslt"}, {32'b0, req_rslt}, {32'b0, e.rslt});
                checks++;
                if (cyc != e.cyc)
                    fail_line({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end

    logic prev_div_ready = 1'b0;
    always @(negedge clk) begin
        if (prev_div_ready) begin
            checks++;
            if (div_valid) fail_line("valid_after_ready", 64'd1, 64'd0);
        end
        prev_div_ready <= div_ready;
    end

    // transaction-level reference: arbitration pointer and result cache
    int          pref = 0;
    int          exp_starts = 0;
    logic        m_cv = 1'b0;
    logic        m_cs;
    logic [31:0] m_ca, m_cb;

    task automatic model_txn(input logic [OPW-1:0] op, input logic [31:0] a,
                             input logic [31:0] b, output logic [31:0] res,
                             output int lat);
        logic s;
        s = (op == DIV) || (op == REM);
        res = ref_op(op, a, b);
        if (b == 0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
            lat = 1;
        end else if (CACHE && m_cv && m_ca == a && m_cb == b && m_cs == s) begin
            lat = 1;
        end else begin
            lat = NORM_LAT;
            exp_starts++;
            if (CACHE) begin
                m_cv = 1'b1;
                m_ca = a;
                m_cb = b;
                m_cs = s;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [OPW-1:0] op,
                            input logic [31:0] a, input logic [31:0] b);
        req_valid[p]           = 1'b1;
        req_op[p*OPW +: OPW]   = op;
        req_divident[p*32 +: 32] = a;
        req_divisor[p*32 +: 32]  = b;
    endtask

    task automatic clr_port(input int p);
        req_valid[p] = 1'b0;
    endtask

    task automatic wait_done(input int p);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready[p]) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            fail_line($sformatf("timeout_port%0d", p), 64'd0, 64'd1);
        end
        step();
    endtask

    task automatic push(input int p, input logic [31:0] r, input longint c,
                        input string n);
        exp_t e;
        e.port = p;
        e.rslt = r;
        e.cyc  = c;
        e.name = n;
        sbq.push_back(e);
    endtask

    task automatic single(input int p, input logic [OPW-1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input string n);
        logic [31:0] r;
        int lat;
        longint k;
        k = cyc;
        set_port(p, op, a, b);
        model_txn(op, a, b, r, lat);
        push(p, r, k + lat, n);
        pref = 1 - p;
        wait_done(p);
        clr_port(p);
    endtask

    task automatic pair(input logic [OPW-1:0] op0, input logic [31:0] a0,
                        input logic [31:0] b0, input logic [OPW-1:0] op1,
                        input logic [31:0] a1, input logic [31:0] b1,
                        input bit chain, input logic [OPW-1:0] opc,
                        input logic [31:0] ac, input logic [31:0] bc,
                        input string n);
        logic [31:0] rf, rs, rc;
        int lf, ls, lc, f, s;
        longint k;
        logic [OPW-1:0] op_a[2];
        logic [31:0] a_a[2], b_a[2];
        op_a[0] = op0; a_a[0] = a0; b_a[0] = b0;
        op_a[1] = op1; a_a[1] = a1; b_a[1] = b1;
        k = cyc;
        set_port(0, op0, a0, b0);
        set_port(1, op1, a1, b1);
        f = pref;
        s = 1 - pref;
        model_txn(op_a[f], a_a[f], b_a[f], rf, lf);
        push(f, rf, k + lf, {n, "_first"});
        model_txn(op_a[s], a_a[s], b_a[s], rs, ls);
        push(s, rs, k + lf + 1 + ls, {n, "_second"});
        wait_done(f);
        if (chain) begin
            set_port(f, opc, ac, bc);
            model_txn(opc, ac, bc, rc, lc);
            push(f, rc, k + lf + 1 + ls + 1 + lc, {n, "_chain"});
            pref = s;
            wait_done(s);
            clr_port(s);
            wait_done(f);
            clr_port(f);
        end else begin
            clr_port(f);
            pref = f;
            wait_done(s);
            clr_port(s);
        end
    endtask

    task automatic rand_operands(output logic [OPW-1:0] op, output logic [31:0] a,
                                 output logic [31:0] b, inout logic [31:0] la,
                                 inout logic [31:0] lb);
        int pick;
        op = OPW'($urandom_range(0, 3));
        pick = $urandom_range(0, 9);
        case (pick)
            0: begin a = $urandom; b = 32'h0; end
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: begin a = la; b = lb; end
            3: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 20); end
            default: begin a = $urandom; b = $urandom | 32'h1; end
        endcase
        if (pick != 0 && b == 0) b = 32'h3;
        la = a;
        lb = b;
    endtask

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) fail_line(n, {32'b0, got}, {32'b0, want});
    endtask

    initial begin
        logic [OPW-1:0] o0, o1;
        logic [31:0] x0, y0, x1, y1, la, lb;
        la = 32'd100;
        lb = 32'd7;
        reset = 1'b1;
        req_valid = '0;
        req_op = '0;
        req_divident = '0;
        req_divisor = '0;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_div_valid", {31'b0, div_valid}, 32'h0);
        chk("rst_req_ready", {30'b0, req_ready}, 32'h0);
        chk("rst_req_rslt", req_rslt, 32'h0);
        chk("rst_div_op", 32'(div_op), 32'h0);
        chk("rst_div_divident", div_divident, 32'h0);
        chk("rst_div_divisor", div_divisor, 32'h0);
        step();

        pair(DIVU, 32'd100, 32'd7, REMU, 32'd100, 32'd7,
             1'b1, DIV, 32'hFFFF_FFEC, 32'd3, "rr_pair");
        single(0, REM, 32'hFFFF_FFEC, 32'd3, "rem_neg");
        single(0, DIVU, 32'd5, 32'd0, "divu_by0");
        single(1, REMU, 32'd5, 32'd0, "remu_by0");
        single(0, DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        single(1, REM, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        single(1, DIVU, 32'd100, 32'd7, "divu_p1");

        set_port(0, DIVU, 32'd1000, 32'd3);
        exp_starts++;
        repeat (12) step();
        reset = 1'b1;
        req_valid = '0;
        step();
        reset = 1'b0;
        pref = 0;
        m_cv = 1'b0;
        @(negedge clk);
        chk("midrst_div_valid", {31'b0, div_valid}, 32'h0);
        chk("midrst_req_ready", {30'b0, req_ready}, 32'h0);
        chk("midrst_req_rslt", req_rslt, 32'h0);
        step();
        single(0, DIVU, 32'd9, 32'd3, "after_rst");

        for (int i = 0; i < 30; i++) begin
            rand_operands(o0, x0, y0, la, lb);
            if ($urandom_range(0, 3) == 0) begin
                rand_operands(o1, x1, y1, la, lb);
                pair(o0, x0, y0, o1, x1, y1, 1'b0, DIV, 32'h0, 32'h1,
                     $sformatf("rnd%0d_pair", i));
            end else begin
                single(int'($urandom_range(0, 1)), o0, x0, y0,
                       $sformatf("rnd%0d", i));
            end
        end

        repeat (5) step();
        chk("queue_empty", sbq.size(), 32'h0);
        chk("div_starts", div_starts, exp_starts);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_share_ctrl.md
Name: div_share_ctrl

Overview:
- Controller and arbiter that shares one radix-2 restoring divider (p23_divider, 32-cycle iterative) between two requesters: port 0 is the core execute stage, port 1 is the secondary requester.
- Round-robin arbitration and operand/op latching.
- Sequences the divider valid/ready handshake.
- Single-cycle fast path for the RISC-V corner cases: divide-by-zero and signed overflow.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- OPW, `DIV_OP_WIDTH, op field width; op encodings are `DIV_OP_DIV/DIVU/REM/REMU from riscv_defines.vh.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  per-port request; held until that port's req_ready pulse
- req_op  in  2*OPW  per-port op, port n at [n*OPW +: OPW]
- req_divident  in  2*XLEN  per-port dividend
- req_divisor  in  2*XLEN  per-port divisor
- req_ready  out  2  one-cycle completion pulse per port
- req_rslt  out  XLEN  result; valid in the req_ready cycle, held until the next completion
- div_valid  out  1  to divider valid
- div_op  out  OPW  to divider DIVop
- div_divident  out  XLEN  to divider
- div_divisor  out  XLEN  to divider
- div_ready  in  1  divider ready pulse
- div_rslt  in  XLEN  divider divOrRemRslt (combinational on div_op)

Interface:
- One clock; reset is synchronous and active-high.
- The divider's resetn is driven as ~reset at the top level, so both blocks reset on the same edge.

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE, plus CAP2 when the cache is enabled.
- Reset values:
  - state=IDLE, div_valid=0, req_ready=0, req_rslt=0.
  - RR pointer=0 (port 0 preferred).
  - Latched op/operands=0; cache invalid.
- IDLE, arbitration:
  - If exactly one req_valid bit is set, grant that port.
  - If both are set, grant the port selected by the RR pointer. After every grant the pointer moves to the non-granted port.
  - A port whose req_ready pulses this cycle is masked for that cycle, so a stale held valid is not re-granted.
- IDLE, latching: on grant, latch op, dividend and divisor; div_op/div_divident/div_divisor are driven from these latches and stay stable until DONE.
- Fast path, from IDLE straight to DONE:
  - Divisor==0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend.
  - Signed op with dividend 0x80000000 and divisor 0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
  - The result is registered and req_ready pulses the cycle after the grant (latency 1).
- Normal path:
  - IDLE to ISSUE: div_valid=1.
  - ISSUE to WAIT next cycle, with div_valid still high.
  - In WAIT, on the cycle div_ready=1: capture div_rslt, clear div_valid (registered, so it is low the next cycle), go to DONE.
  - div_valid must be low before the divider returns to IDLE with ready=0; it must never re-trigger.
- DONE: pulse req_ready[granted]=1 for exactly one cycle with req_rslt valid, then return to IDLE.
- Latency, normal path: 36 cycles from grant to req_ready; the bench checks ±0 against RTL golden.
- Requester protocol: requesters must not change op/operands while req_valid is high. The controller latches them at grant, so a later change is ignored.
- A requester drops req_valid after its pulse. If it is still high in the next IDLE, that is treated as a new request.
- Reset mid-operation (any state): return to reset values immediately, drop div_valid, and emit no req_ready. The divider resets concurrently.
- The non-granted port waits; there is no starvation, since it is guaranteed the next grant.

Optional Feature:
- Macro: DIV_RESULT_CACHE_EN.
- Enabled:
  - After a normal-path div_ready capture, enter CAP2 for one cycle. Drive div_op to the complementary op of the same signedness (DIV<->REM, DIVU<->REMU) and capture div_rslt as the other result. The divider holds both internally.
  - Store {dividend, divisor, signed, quotient, remainder}, mark the cache valid, then go to DONE. Normal-path latency becomes 37.
  - A later grant whose dividend, divisor and signedness match a valid cache entry completes with latency 1 from the cache, in either port.
  - Fast-path results do not update the cache.
- Disabled: no CAP2 state, no cache storage, no hit path.

Test Plan:
- DIVU 100/7 on port 0 → req_rslt=14, req_ready[0] pulses 36 cycles after grant; REMU 100/7 → 2.
- DIV 0xFFFFFFEC(-20)/3 → 0xFFFFFFFA; REM same operands → 0xFFFFFFFE. With DIV_RESULT_CACHE_EN, the REM issued right after hits with latency 1.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0. All with latency 1 and div_valid never asserted.
- Both ports valid in the same cycle, twice in a row:
  - First round: port 0 served first, then port 1.
  - Second simultaneous pair: port 1 first.
  - Each port gets exactly one req_ready pulse per request.
- Assert reset 10 cycles into WAIT → div_valid=0 and state IDLE next cycle, no req_ready. A fresh DIVU 9/3 afterwards → 3.
- Protocol check throughout: div_valid is low in the cycle after div_ready, and the divider never starts twice per grant.
